// File: rtl/rrs_alu_block.sv
// ---------------------------------------------------------------------------
// rrs_alu_block
//
// Register-result-status (RRS) table combined with a one-cycle ADD/MUL
// execute stage for the Tomasulo core. Each architectural register holds
// either a ready value (tag == READY_TAG) or the tag of the unit that will
// produce it. The execute stage registers its tagged result and broadcasts
// it on the CDB for one cycle. Each edge, that broadcast and an external
// broadcast resolve every pending register whose tag matches.
//
// Optional feature macro: RRS_BYPASS_EN
//   When defined, the read port forwards a same-cycle broadcast value to a
//   register that is waiting on that tag. When undefined, the read port
//   shows only the registered table state.
//
// Ports
//   clk         clock
//   rst_n       asynchronous active-low reset
//   rd_addr     read-port register address
//   rd_tag      tag of rd_addr (combinational)
//   rd_value    value of rd_addr (combinational)
//   wr_en       rename/assign strobe
//   wr_addr     register to assign
//   wr_tag      new producer tag; READY_TAG means immediate move
//   wr_value    value stored when wr_tag == READY_TAG
//   ex_valid    issue an operation to the execute stage
//   ex_op       0 = ADD, 1 = MUL
//   ex_tag      tag attached to the result
//   ex_a, ex_b  signed operands
//   xcdb_valid  external CDB broadcast valid
//   xcdb_tag    external CDB tag
//   xcdb_value  external CDB value
//   cdb_valid   registered ALU broadcast valid
//   cdb_tag     registered ALU broadcast tag
//   cdb_value   registered ALU broadcast value
// ---------------------------------------------------------------------------
module rrs_alu_block #(
    parameter int              NUM_REGS  = 64,
    parameter int              TAG_W     = 8,
    parameter int              WORD_W    = 32,
    parameter logic [TAG_W-1:0] READY_TAG = 8'h7F,
    localparam int             ADDR_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [WORD_W-1:0] rd_value,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD_W-1:0] wr_value,
    input  logic              ex_valid,
    input  logic              ex_op,
    input  logic [TAG_W-1:0]  ex_tag,
    input  logic [WORD_W-1:0] ex_a,
    input  logic [WORD_W-1:0] ex_b,
    input  logic              xcdb_valid,
    input  logic [TAG_W-1:0]  xcdb_tag,
    input  logic [WORD_W-1:0] xcdb_value,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [WORD_W-1:0] cdb_value
);

    logic [TAG_W-1:0]  tag_q   [NUM_REGS];
    logic [WORD_W-1:0] value_q [NUM_REGS];

    logic [WORD_W-1:0] ex_result;
    logic              ex_accept;
    logic              alu_bcast;
    logic              ext_bcast;

    // Execute datapath. The low WORD_W bits of a two's-complement product
    // do not depend on operand signedness, so a plain WORD_W-bit multiply
    // gives the low half of the signed product without a double-width result.
    always_comb begin
        ex_result = ex_a + ex_b;
        if (ex_op) begin
            ex_result = ex_a * ex_b;
        end
    end

    // A READY_TAG result would be indistinguishable from "no producer", so
    // such an issue is dropped. Broadcasts carrying READY_TAG never resolve.
    assign ex_accept = ex_valid && (ex_tag != READY_TAG);
    assign alu_bcast = cdb_valid && (cdb_tag != READY_TAG);
    assign ext_bcast = xcdb_valid && (xcdb_tag != READY_TAG);

    // Result register: the broadcast is valid for exactly the cycle after
    // the issue edge. Tag and value only load on an accepted issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= READY_TAG;
            cdb_value <= '0;
        end else begin
            cdb_valid <= ex_accept;
            if (ex_accept) begin
                cdb_tag   <= ex_tag;
                cdb_value <= ex_result;
            end
        end
    end

    // Table update. Each entry applies the highest-priority event aimed at
    // it: a rename write first (it names a newer producer), then the ALU
    // broadcast, then the external broadcast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                tag_q[i]   <= READY_TAG;
                value_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    tag_q[i] <= wr_tag;
                    if (wr_tag == READY_TAG) begin
                        value_q[i] <= wr_value;
                    end
                end else if (alu_bcast && (tag_q[i] == cdb_tag)) begin
                    tag_q[i]   <= READY_TAG;
                    value_q[i] <= cdb_value;
                end else if (ext_bcast && (tag_q[i] == xcdb_tag)) begin
                    tag_q[i]   <= READY_TAG;
                    value_q[i] <= xcdb_value;
                end
            end
        end
    end

    // Read port. With bypass enabled, a register waiting on a tag that is
    // being broadcast this cycle already reads as ready with that value.
    always_comb begin
        rd_tag   = tag_q[rd_addr];
        rd_value = value_q[rd_addr];
`ifdef RRS_BYPASS_EN
        if (alu_bcast && (tag_q[rd_addr] == cdb_tag)) begin
            rd_tag   = READY_TAG;
            rd_value = cdb_value;
        end else if (ext_bcast && (tag_q[rd_addr] == xcdb_tag)) begin
            rd_tag   = READY_TAG;
            rd_value = xcdb_value;
        end
`endif
    end

endmodule

// File: tb/tb_rrs_alu_block.sv
// ---------------------------------------------------------------------------
// tb_rrs_alu_block
//
// Directed testbench for rrs_alu_block. Inputs change just after the falling
// edge and outputs are sampled shortly after that, well away from the rising
// edge the design uses.
// ---------------------------------------------------------------------------
module tb_rrs_alu_block;

    localparam logic [7:0] RDY = 8'h7F;

    logic        clk;
    logic        rst_n;
    logic [5:0]  rd_addr;
    logic [7:0]  rd_tag;
    logic [31:0] rd_value;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_tag;
    logic [31:0] wr_value;
    logic        ex_valid;
    logic        ex_op;
    logic [7:0]  ex_tag;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        xcdb_valid;
    logic [7:0]  xcdb_tag;
    logic [31:0] xcdb_value;
    logic        cdb_valid;
    logic [7:0]  cdb_tag;
    logic [31:0] cdb_value;

    int vectors;
    int miscompares;

    rrs_alu_block dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_addr    (rd_addr),
        .rd_tag     (rd_tag),
        .rd_value   (rd_value),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_tag     (wr_tag),
        .wr_value   (wr_value),
        .ex_valid   (ex_valid),
        .ex_op      (ex_op),
        .ex_tag     (ex_tag),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .xcdb_valid (xcdb_valid),
        .xcdb_tag   (xcdb_tag),
        .xcdb_value (xcdb_value),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_value  (cdb_value)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net in case the stimulus ever stops making progress.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one rising edge and come back to the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Point the read port at a register and let the combinational path settle.
    task automatic read_reg(input logic [5:0] addr);
        rd_addr = addr;
        #1;
    endtask

    task automatic idle_inputs();
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_tag     = RDY;
        wr_value   = '0;
        ex_valid   = 1'b0;
        ex_op      = 1'b0;
        ex_tag     = RDY;
        ex_a       = '0;
        ex_b       = '0;
        xcdb_valid = 1'b0;
        xcdb_tag   = RDY;
        xcdb_value = '0;
    endtask

    // Single-cycle rename write, then inputs return to idle.
    task automatic rename(input logic [5:0] addr, input logic [7:0] tag, input logic [31:0] val);
        wr_en    = 1'b1;
        wr_addr  = addr;
        wr_tag   = tag;
        wr_value = val;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rd_addr = '0;
        rst_n   = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) begin
            read_reg(6'(i));
            vectors++;
            if (rd_tag !== RDY || rd_value !== 32'd0) begin
                miscompares++;
                $display("[TB] FAIL reset_entry[%0d]: got tag=%h value=%h, want tag=7f value=0", i, rd_tag, rd_value);
            end
        end
        vectors++;
        if (cdb_valid !== 1'b0 || cdb_tag !== RDY || cdb_value !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_cdb: got valid=%b tag=%h value=%h, want 0/7f/0", cdb_valid, cdb_tag, cdb_value);
        end
    endtask

    task automatic test_move_immediate();
        @(negedge clk);
        rename(6'd5, RDY, 32'd42);
        read_reg(6'd5);
        vectors++;
        if (rd_tag !== RDY || rd_value !== 32'd42) begin
            miscompares++;
            $display("[TB] FAIL move_imm: got tag=%h value=%h, want 7f/0000002a", rd_tag, rd_value);
        end
    endtask

    task automatic test_rename_add();
        rename(6'd3, 8'h20, 32'd0);
        read_reg(6'd3);
        vectors++;
        if (rd_tag !== 8'h20) begin
            miscompares++;
            $display("[TB] FAIL rename_pending: got tag=%h, want 20", rd_tag);
        end
        ex_valid = 1'b1;
        ex_op    = 1'b0;
        ex_tag   = 8'h20;
        ex_a     = -32'sd7;
        ex_b     = 32'd10;
        tick();
        ex_valid = 1'b0;
        #1;
        vectors++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 8'h20 || cdb_value !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL add_cdb: got valid=%b tag=%h value=%h, want 1/20/00000003", cdb_valid, cdb_tag, cdb_value);
        end
        // Broadcast is live this cycle; the stored entry is still pending.
        read_reg(6'd3);
        vectors++;
`ifdef RRS_BYPASS_EN
        if (rd_tag !== RDY || rd_value !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL bypass_read: got tag=%h value=%h, want 7f/00000003", rd_tag, rd_value);
        end
`else
        if (rd_tag !== 8'h20) begin
            miscompares++;
            $display("[TB] FAIL no_bypass_read: got tag=%h, want 20", rd_tag);
        end
`endif
        tick();
        read_reg(6'd3);
        vectors++;
        if (rd_tag !== RDY || rd_value !== 32'd3) begin
            miscompares++;
            $display("[TB] FAIL add_resolve: got tag=%h value=%h, want 7f/00000003", rd_tag, rd_value);
        end
        vectors++;
        if (cdb_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL cdb_one_cycle: got valid=%b, want 0", cdb_valid);
        end
    endtask

    task automatic test_mul_back_to_back();
        ex_valid = 1'b1;
        ex_op    = 1'b1;
        ex_tag   = 8'h30;
        ex_a     = 32'h0001_0000;
        ex_b     = 32'h0001_0000;
        tick();
        vectors++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 8'h30 || cdb_value !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL mul_wrap: got valid=%b tag=%h value=%h, want 1/30/00000000", cdb_valid, cdb_tag, cdb_value);
        end
        ex_tag = 8'h31;
        ex_a   = -32'sd3;
        ex_b   = 32'd5;
        tick();
        vectors++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 8'h31 || cdb_value !== 32'hFFFF_FFF1) begin
            miscompares++;
            $display("[TB] FAIL mul_neg: got valid=%b tag=%h value=%h, want 1/31/fffffff1", cdb_valid, cdb_tag, cdb_value);
        end
        ex_op  = 1'b0;
        ex_tag = 8'h32;
        ex_a   = 32'hFFFF_FFFF;
        ex_b   = 32'd2;
        tick();
        ex_valid = 1'b0;
        vectors++;
        if (cdb_valid !== 1'b1 || cdb_tag !== 8'h32 || cdb_value !== 32'd1) begin
            miscompares++;
            $display("[TB] FAIL add_wrap: got valid=%b tag=%h value=%h, want 1/32/00000001", cdb_valid, cdb_tag, cdb_value);
        end
    endtask

    task automatic test_illegal_tag();
        ex_valid = 1'b1;
        ex_op    = 1'b0;
        ex_tag   = RDY;
        ex_a     = 32'd1;
        ex_b     = 32'd1;
        tick();
        ex_valid = 1'b0;
        vectors++;
        if (cdb_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL illegal_tag: got valid=%b, want 0", cdb_valid);
        end
    endtask

    task automatic test_multi_match();
        rename(6'd1, 8'h40, 32'd0);
        rename(6'd2, 8'h40, 32'd0);
        rename(6'd9, 8'h80, 32'd0);
        ex_valid = 1'b1;
        ex_op    = 1'b0;
        ex_tag   = 8'h40;
        ex_a     = 32'd2;
        ex_b     = 32'd4;
        tick();
        ex_valid   = 1'b0;
        xcdb_valid = 1'b1;
        xcdb_tag   = 8'h80;
        xcdb_value = 32'd9;
        tick();
        xcdb_valid = 1'b0;
        read_reg(6'd1);
        vectors++;
        if (rd_tag !== RDY || rd_value !== 32'd6) begin
            miscompares++;
            $display("[TB] FAIL multi_reg1: got tag=%h value=%h, want 7f/00000006", rd_tag, rd_value);
        end
        read_reg(6'd2);
        vectors++;
        if (rd_tag !== RDY || rd_value !== 32'd6) begin
            miscompares++;
            $display("[TB] FAIL multi_reg2: got tag=%h value=%h, want 7f/00000006", rd_tag, rd_value);
        end
        read_reg(6'd9);
        vectors++;
        if (rd_tag !== RDY || rd_value !== 32'd9) begin
            miscompares++;
            $display("[TB] FAIL multi_reg9: got tag=%h value=%h, want 7f/00000009", rd_tag, rd_value);
        end
    endtask

    task automatic test_rename_race();
        rename(6'd1, 8'h40, 32'd0);
        rename(6'd2, 8'h40, 32'd0);
        ex_valid = 1'b1;
        ex_op    = 1'b0;
        ex_tag   = 8'h40;
        ex_a     = 32'd100;
        ex_b     = 32'd5;
        tick();
        ex_valid = 1'b0;
        wr_en    = 1'b1;
        wr_addr  = 6'd1;
        wr_tag   = 8'h41;
        wr_value = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        read_reg(6'd1);
        vectors++;
        if (rd_tag !== 8'h41 || rd_value !== 32'd6) begin
            miscompares++;
            $display("[TB] FAIL race_reg1: got tag=%h value=%h, want 41/00000006", rd_tag, rd_value);
        end
        read_reg(6'd2);
        vectors++;
        if (rd_tag !== RDY || rd_value !== 32'd105) begin
            miscompares++;
            $display("[TB] FAIL race_reg2: got tag=%h value=%h, want 7f/00000069", rd_tag, rd_value);
        end
    endtask

    task automatic test_same_tag_priority();
        rename(6'd10, 8'h50, 32'd0);
        ex_valid = 1'b1;
        ex_op    = 1'b0;
        ex_tag   = 8'h50;
        ex_a     = 32'd1;
        ex_b     = 32'd1;
        tick();
        ex_valid   = 1'b0;
        xcdb_valid = 1'b1;
        xcdb_tag   = 8'h50;
        xcdb_value = 32'd99;
        tick();
        xcdb_valid = 1'b0;
        read_reg(6'd10);
        vectors++;
        if (rd_tag !== RDY || rd_value !== 32'd2) begin
            miscompares++;
            $display("[TB] FAIL same_tag_alu_wins: got tag=%h value=%h, want 7f/00000002", rd_tag, rd_value);
        end
    endtask

    task automatic test_ready_bcast_ignored();
        xcdb_valid = 1'b1;
        xcdb_tag   = RDY;
        xcdb_value = 32'd1234;
        tick();
        xcdb_valid = 1'b0;
        read_reg(6'd5);
        vectors++;
        if (rd_tag !== RDY || rd_value !== 32'd42) begin
            miscompares++;
            $display("[TB] FAIL ready_bcast_ignored: got tag=%h value=%h, want 7f/0000002a", rd_tag, rd_value);
        end
    endtask

    // External broadcast on its own resolves a pending register.
    task automatic test_external_only();
        rename(6'd63, 8'h90, 32'd0);
        xcdb_valid = 1'b1;
        xcdb_tag   = 8'h90;
        xcdb_value = 32'hCAFE_F00D;
        tick();
        xcdb_valid = 1'b0;
        read_reg(6'd63);
        vectors++;
        if (rd_tag !== RDY || rd_value !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("[TB] FAIL xcdb_resolve: got tag=%h value=%h, want 7f/cafef00d", rd_tag, rd_value);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        $display("[TB] starting rrs_alu_block directed tests");
        test_reset();
        test_move_immediate();
        test_rename_add();
        test_mul_back_to_back();
        test_illegal_tag();
        test_multi_match();
        test_rename_race();
        test_same_tag_priority();
        test_ready_bcast_ignored();
        test_external_only();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
